// File: rtl/stack_sequencer.sv
// ============================================================================
//  Module   : stack_sequencer
//  Purpose  : Performs the multi-cycle stack transfers requested by the
//             controller FSM: pushes the return PC (and, on interrupt entry,
//             the flag byte) and pops them back for RTS/RTI. Owns the stack
//             pointer and drives the data-memory bus with a req/grant
//             handshake. A one-cycle done pulse ends every operation.
//  Options  : `define STACK_LIMIT_CHECK_EN to enable overflow/underflow
//             detection (sticky stack_err, cleared by err_clr). Without it
//             the stack pointer wraps freely and stack_err stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_sequencer #(
  parameter logic [7:0] STACK_HI = 8'hFF,
  parameter logic [7:0] STACK_LO = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       push_or_pop,
  input  logic       two_byte,
  input  logic [7:0] pc_in,
  input  logic [5:0] flags_in,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic [7:0] mem_addr,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       done,
  output logic [7:0] pc_out,
  output logic       pc_load,
  output logic [5:0] flags_out,
  output logic       flags_load,
  output logic [7:0] sp,
  output logic       stack_err,
  input  logic       err_clr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_PC = 3'd1,
    S_PUSH_FL = 3'd2,
    S_POP_FL  = 3'd3,
    S_POP_PC  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [7:0] r_sp;
  logic [7:0] r_pc_lat;
  logic [5:0] r_fl_lat;
  logic       r_two;
  logic       r_pop;
  logic       r_err_op;
  logic [7:0] r_pc_out;
  logic [5:0] r_flags_out;

  logic       w_err;
  logic [7:0] w_sp_inc;
  logic [7:0] w_sp_dec;

  // Only the low six bits of a popped flag byte carry state.
  logic [1:0] w_unused_rdata_hi;
  assign w_unused_rdata_hi = mem_rdata[7:6];

  // SP points at the next free byte: pushes write at SP, pops read at SP+1.
  assign w_sp_inc = r_sp + 8'd1;
  assign w_sp_dec = r_sp - 8'd1;

`ifdef STACK_LIMIT_CHECK_EN
  logic r_stack_err;

  // Limit check made before each byte: a push below STACK_LO or a pop from an
  // empty stack aborts the operation without touching the bus.
  always_comb begin
    w_err = 1'b0;
    case (r_state)
      S_PUSH_PC, S_PUSH_FL: w_err = (r_sp < STACK_LO);
      S_POP_FL, S_POP_PC:   w_err = (r_sp == STACK_HI);
      default:              w_err = 1'b0;
    endcase
  end

  // Sticky error flag; a new error in the same cycle outranks err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stack_err <= 1'b0;
    end else if (w_err) begin
      r_stack_err <= 1'b1;
    end else if (err_clr) begin
      r_stack_err <= 1'b0;
    end
  end

  assign stack_err = r_stack_err;
`else
  logic [8:0] w_unused_limit;
  assign w_unused_limit = {err_clr, STACK_LO};
  assign w_err          = 1'b0;
  assign stack_err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and bus/strobe outputs for the current state.
  always_comb begin
    w_next     = r_state;
    bus_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = 8'h00;
    mem_wdata  = 8'h00;
    done       = 1'b0;
    pc_load    = 1'b0;
    flags_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (push_or_pop) begin
            w_next = S_PUSH_PC;
          end else if (two_byte) begin
            w_next = S_POP_FL;
          end else begin
            w_next = S_POP_PC;
          end
        end
      end
      S_PUSH_PC: begin
        if (w_err) begin
          w_next = S_DONE;
        end else begin
          bus_req   = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = r_sp;
          mem_wdata = r_pc_lat;
          if (bus_grant) begin
            w_next = r_two ? S_PUSH_FL : S_DONE;
          end
        end
      end
      S_PUSH_FL: begin
        if (w_err) begin
          w_next = S_DONE;
        end else begin
          bus_req   = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = r_sp;
          mem_wdata = {2'b00, r_fl_lat};
          if (bus_grant) begin
            w_next = S_DONE;
          end
        end
      end
      S_POP_FL: begin
        if (w_err) begin
          w_next = S_DONE;
        end else begin
          bus_req  = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = w_sp_inc;
          if (bus_grant) begin
            w_next = S_POP_PC;
          end
        end
      end
      S_POP_PC: begin
        if (w_err) begin
          w_next = S_DONE;
        end else begin
          bus_req  = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = w_sp_inc;
          if (bus_grant) begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        pc_load    = r_pop & ~r_err_op;
        flags_load = r_pop & r_two & ~r_err_op;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand latching, stack pointer updates and popped-value capture; SP
  // moves only on granted bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp        <= STACK_HI;
      r_pc_lat    <= 8'h00;
      r_fl_lat    <= 6'h00;
      r_two       <= 1'b0;
      r_pop       <= 1'b0;
      r_err_op    <= 1'b0;
      r_pc_out    <= 8'h00;
      r_flags_out <= 6'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc_lat <= pc_in;
            r_fl_lat <= flags_in;
            r_two    <= two_byte;
            r_pop    <= ~push_or_pop;
            r_err_op <= 1'b0;
          end
        end
        S_PUSH_PC, S_PUSH_FL: begin
          if (w_err) begin
            r_err_op <= 1'b1;
          end else if (bus_grant) begin
            r_sp <= w_sp_dec;
          end
        end
        S_POP_FL: begin
          if (w_err) begin
            r_err_op <= 1'b1;
          end else if (bus_grant) begin
            r_flags_out <= mem_rdata[5:0];
            r_sp        <= w_sp_inc;
          end
        end
        S_POP_PC: begin
          if (w_err) begin
            r_err_op <= 1'b1;
          end else if (bus_grant) begin
            r_pc_out <= mem_rdata;
            r_sp     <= w_sp_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sp        = r_sp;
  assign pc_out    = r_pc_out;
  assign flags_out = r_flags_out;

endmodule

`default_nettype wire
